bullet_pool: RTL
================

BULLET_POOL -- requirements
Module: bullet_pool

Interface
REQ-001 Parameter NUM_BULLETS, default 4, number of bullet slots; fixed at 4 for slot index width 2.
REQ-002 Parameter TICK_CYCLES, default 833333, clk cycles per movement tick.
REQ-003 Parameter BULLET_LIFE, default 40, ticks a bullet lives after spawn.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 fire  in  1  level shoot request from ship; spawns on rising edge only.
REQ-007 ship_x  in  8  ship x, 0..159.
REQ-008 ship_y  in  7  ship y, 0..119.
REQ-009 dir_x, dir_y  in  2 each  ship heading; 00 none, 01 +, 10 -, 11 none.
REQ-010 hit_valid, hit_idx  in  1, 2  collision kill request for slot hit_idx.
REQ-011 draw_valid, draw_x, draw_y, draw_erase  out  1, 8, 7, 1  pixel plot request; erase=1 means background colour.
REQ-012 draw_ready  in  1  plotter accepts request when high with draw_valid.
REQ-013 bullet_active  out  4  per-slot live flag; active_count  out  3  number of live slots.

Function
REQ-014 Per slot: x[7:0], y[6:0], vx/vy[1:0] (captured dir), life[5:0], active, drawn.
REQ-015 Tick counter counts TICK_CYCLES-1 down to 0, reloads; on 0 sets tick_pending; a second tick while pending is lost.
REQ-016 Fire edge (fire=1, previous sample 0) sets fire_pending; further edges while pending are lost.
REQ-017 Fire with dir_x and dir_y both none/11 is discarded.
REQ-018 FSM states IDLE, SPAWN, ERASE, MOVE, DRAW, NEXT.
REQ-019 IDLE: fire_pending -> SPAWN (priority); else tick_pending -> ERASE with slot=0, clear tick_pending.
REQ-020 SPAWN (1 cycle): lowest-index slot with active=0 and drawn=0 loads ship_x/ship_y, dir, life=BULLET_LIFE, active=1, drawn=0; none free -> request dropped; clear fire_pending; -> IDLE.
REQ-021 ERASE: slot drawn=1 -> issue erase at old x,y; on handshake drawn=0 -> MOVE; drawn=0 -> MOVE directly.
REQ-022 MOVE (1 cycle): active slot steps 2 px per axis in captured direction, life decrements; life reaching 0 clears active; inactive slot unchanged.
REQ-023 X wraps mod 160: x+2>=160 -> x+2-160; x<2 moving - -> x-2+160. Y identical mod 120.
REQ-024 DRAW: active slot -> issue draw at new x,y; on handshake drawn=1 -> NEXT; inactive -> NEXT.
REQ-025 NEXT: slot<3 -> slot+1, ERASE; slot=3 -> IDLE.
REQ-026 draw_valid holds with stable draw_x/y/erase until draw_ready; no request is ever withdrawn.
REQ-027 hit_valid on an active slot clears active that cycle; drawn stays set so the next scan erases it; hit on inactive slot ignored.
REQ-028 Hit on the slot in MOVE or DRAW wins: no redraw of that slot.
REQ-029 Slot is reusable only after active=0 and drawn=0.
REQ-030 active_count = popcount(active), combinational from registers.

Reset
REQ-031 Reset low: all slot fields, pending flags, fire edge register, draw_valid, draw_x, draw_y, draw_erase, bullet_active cleared to 0; FSM IDLE; tick counter loads TICK_CYCLES-1.
REQ-032 Reset mid-handshake aborts the request immediately; no erase is issued afterward.

Structure
REQ-033 Package game_pkg holds SCREEN_W=160, SCREEN_H=120, direction encoding constants, FSM state typedef.
REQ-034 Sub-module wrap_step: one axis, position, dir, modulus -> next position; instantiated per axis.

Verification (TICK_CYCLES=4, BULLET_LIFE=3, draw_ready=1 unless stated)
REQ-035 Ship (80,60), dir_x=01, dir_y=00, fire pulse -> slot0 active at (80,60); first scan draws (82,60) erase=0; next scan erases (82,60), draws (84,60).
REQ-036 Ship (159,0), dir_x=01, dir_y=10 -> after one tick bullet at (1,118).
REQ-037 Five fire edges with ticks stalled -> slots 0..3 active, active_count=4, fifth dropped.
REQ-038 BULLET_LIFE=3 -> third move clears active, erase issued, no draw; slot then reusable.
REQ-039 hit_valid idx=0 on drawn slot0 -> bullet_active[0]=0 next cycle; next scan erases old pixel, no draw.
REQ-040 draw_ready low 10 cycles during DRAW -> draw_valid and fields held stable; reset asserted mid-stall -> draw_valid 0 immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen geometry, heading codes, FSM state encoding and the per-slot
// record used by the bullet pool.
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [1:0] DIR_NONE     = 2'b00;
  localparam logic [1:0] DIR_POS      = 2'b01;
  localparam logic [1:0] DIR_NEG      = 2'b10;
  localparam logic [1:0] DIR_NONE_ALT = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SPAWN = 3'd1;
  localparam state_t ST_ERASE = 3'd2;
  localparam state_t ST_MOVE  = 3'd3;
  localparam state_t ST_DRAW  = 3'd4;
  localparam state_t ST_NEXT  = 3'd5;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] vx;
    logic [1:0] vy;
    logic [5:0] life;
    logic       active;
    logic       drawn;
  } slot_t;

  function automatic logic dir_moves(input logic [1:0] d);
    return !((d == DIR_NONE) || (d == DIR_NONE_ALT));
  endfunction

endpackage

// File: rtl/wrap_step.sv
// One-axis position update: step 2 px in the given heading, wrapping
// modulo the screen extent on that axis.
module wrap_step
  import game_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = SCREEN_W
) (
  input  logic [WIDTH-1:0] pos,
  input  logic [1:0]       dir,
  output logic [WIDTH-1:0] next_pos
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] STEP  = (WIDTH+1)'(2);

  logic [WIDTH:0] pos_w;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  always_comb begin
    pos_w    = {1'b0, pos};
    inc      = pos_w + STEP;
    dec      = pos_w - STEP;
    next_pos = pos;
    if (dir == DIR_POS) begin
      next_pos = (inc >= MOD_W) ? WIDTH'(inc - MOD_W) : WIDTH'(inc);
    end else if (dir == DIR_NEG) begin
      // dec underflows when pos < 2; adding the modulus folds it back on screen
      next_pos = (pos_w < STEP) ? WIDTH'(dec + MOD_W) : WIDTH'(dec);
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Fixed pool of bullets: spawns on fire edges, moves all live bullets once per
// tick with erase/redraw requests to a pixel plotter, and honours kill requests.
module bullet_pool
  import game_pkg::*;
#(
  parameter int NUM_BULLETS = 4,
  parameter int TICK_CYCLES = 833333,
  parameter int BULLET_LIFE = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fire,
  input  logic [7:0]             ship_x,
  input  logic [6:0]             ship_y,
  input  logic [1:0]             dir_x,
  input  logic [1:0]             dir_y,
  input  logic                   hit_valid,
  input  logic [1:0]             hit_idx,
  output logic                   draw_valid,
  output logic [7:0]             draw_x,
  output logic [6:0]             draw_y,
  output logic                   draw_erase,
  input  logic                   draw_ready,
  output logic [NUM_BULLETS-1:0] bullet_active,
  output logic [2:0]             active_count
);

  localparam int             TW          = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0]  TICK_RELOAD = TW'(TICK_CYCLES - 1);
  localparam logic [5:0]     LIFE_INIT   = 6'(BULLET_LIFE);
  localparam logic [1:0]     LAST_SLOT   = 2'(NUM_BULLETS - 1);

  state_t        state_q, state_d;
  logic [1:0]    slot_idx_q, slot_idx_d;
  slot_t         slot_q [NUM_BULLETS];
  slot_t         slot_d [NUM_BULLETS];
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_pending_q, tick_pending_d;
  logic          fire_pending_q, fire_pending_d;
  logic          fire_prev_q, fire_prev_d;
  logic          draw_valid_q, draw_valid_d;
  logic [7:0]    draw_x_q, draw_x_d;
  logic [6:0]    draw_y_q, draw_y_d;
  logic          draw_erase_q, draw_erase_d;

  slot_t      cur_slot;
  logic [7:0] next_x;
  logic [6:0] next_y;
  logic       handshake;
  logic       free_found;
  logic [1:0] free_idx;
  logic       fire_ok;
  logic       cur_hit;

  assign cur_slot  = slot_q[slot_idx_q];
  assign handshake = draw_valid_q && draw_ready;
  assign fire_ok   = dir_moves(dir_x) || dir_moves(dir_y);
  assign cur_hit   = hit_valid && (hit_idx == slot_idx_q);

  wrap_step #(.WIDTH(8), .MODULUS(SCREEN_W)) u_wrap_x (
    .pos      (cur_slot.x),
    .dir      (cur_slot.vx),
    .next_pos (next_x)
  );

  wrap_step #(.WIDTH(7), .MODULUS(SCREEN_H)) u_wrap_y (
    .pos      (cur_slot.y),
    .dir      (cur_slot.vy),
    .next_pos (next_y)
  );

  // A slot is only reusable once its last pixel has been erased.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!slot_q[i].active && !slot_q[i].drawn) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bullet_active[i] = slot_q[i].active;
      active_count     = active_count + 3'(slot_q[i].active);
    end
  end

  always_comb begin
    state_d        = state_q;
    slot_idx_d     = slot_idx_q;
    slot_d         = slot_q;
    tick_pending_d = tick_pending_q;
    fire_pending_d = fire_pending_q;
    fire_prev_d    = fire;
    draw_valid_d   = draw_valid_q;
    draw_x_d       = draw_x_q;
    draw_y_d       = draw_y_q;
    draw_erase_d   = draw_erase_q;

    case (state_q)
      ST_IDLE: begin
        if (fire_pending_q) begin
          state_d = ST_SPAWN;
        end else if (tick_pending_q) begin
          state_d        = ST_ERASE;
          slot_idx_d     = '0;
          tick_pending_d = 1'b0;
        end
      end
      ST_SPAWN: begin
        if (free_found && fire_ok) begin
          slot_d[free_idx] = '{x: ship_x, y: ship_y, vx: dir_x, vy: dir_y,
                               life: LIFE_INIT, active: 1'b1, drawn: 1'b0};
        end
        fire_pending_d = 1'b0;
        state_d        = ST_IDLE;
      end
      ST_ERASE: begin
        if (!cur_slot.drawn) begin
          state_d = ST_MOVE;
        end else if (handshake) begin
          draw_valid_d                = 1'b0;
          slot_d[slot_idx_q].drawn    = 1'b0;
          state_d                     = ST_MOVE;
        end else if (!draw_valid_q) begin
          draw_valid_d = 1'b1;
          draw_x_d     = cur_slot.x;
          draw_y_d     = cur_slot.y;
          draw_erase_d = 1'b1;
        end
      end
      ST_MOVE: begin
        if (cur_slot.active) begin
          slot_d[slot_idx_q].x    = next_x;
          slot_d[slot_idx_q].y    = next_y;
          slot_d[slot_idx_q].life = cur_slot.life - 6'd1;
          if (cur_slot.life <= 6'd1) begin
            slot_d[slot_idx_q].active = 1'b0;
          end
        end
        state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (handshake) begin
          draw_valid_d             = 1'b0;
          slot_d[slot_idx_q].drawn = 1'b1;
          state_d                  = ST_NEXT;
        end else if (!draw_valid_q) begin
          // A kill landing this cycle suppresses the redraw of this slot
          if (cur_slot.active && !cur_hit) begin
            draw_valid_d = 1'b1;
            draw_x_d     = cur_slot.x;
            draw_y_d     = cur_slot.y;
            draw_erase_d = 1'b0;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_NEXT: begin
        if (slot_idx_q == LAST_SLOT) begin
          state_d = ST_IDLE;
        end else begin
          slot_idx_d = slot_idx_q + 2'd1;
          state_d    = ST_ERASE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Kills override any move result; drawn stays so the next scan erases it.
    if (hit_valid && slot_q[hit_idx].active) begin
      slot_d[hit_idx].active = 1'b0;
    end

    // New requests are merged after the FSM so an edge or tick arriving in the
    // consuming cycle is kept rather than cleared.
    if (fire && !fire_prev_q && fire_ok) begin
      fire_pending_d = 1'b1;
    end

    if (tick_cnt_q == '0) begin
      tick_cnt_d     = TICK_RELOAD;
      tick_pending_d = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      slot_idx_q     <= '0;
      slot_q         <= '{default: '0};
      tick_cnt_q     <= TICK_RELOAD;
      tick_pending_q <= 1'b0;
      fire_pending_q <= 1'b0;
      fire_prev_q    <= 1'b0;
      draw_valid_q   <= 1'b0;
      draw_x_q       <= '0;
      draw_y_q       <= '0;
      draw_erase_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_idx_q     <= slot_idx_d;
      slot_q         <= slot_d;
      tick_cnt_q     <= tick_cnt_d;
      tick_pending_q <= tick_pending_d;
      fire_pending_q <= fire_pending_d;
      fire_prev_q    <= fire_prev_d;
      draw_valid_q   <= draw_valid_d;
      draw_x_q       <= draw_x_d;
      draw_y_q       <= draw_y_d;
      draw_erase_q   <= draw_erase_d;
    end
  end

  assign draw_valid = draw_valid_q;
  assign draw_x     = draw_x_q;
  assign draw_y     = draw_y_q;
  assign draw_erase = draw_erase_q;

endmodule
